dds_phase_gen: RTL



---
 rtl/dds_pkg.sv | 27 ++
 rtl/dds_lfsr.sv | 26 ++
 rtl/dds_phase_gen.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/dds_pkg.sv
// Shared types and constants for the DDS phase front end.
// No logic; state encoding, LFSR constants and config field layout.
// Not applicable (package only).
package dds_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        SWEEP = 2'd2
    } state_t;

    // Right-shifting Galois form of x^32+x^22+x^2+x+1: taps at bits 31, 21, 1, 0.
    localparam logic [31:0] LFSR_POLY = 32'h8020_0003;
    localparam logic [31:0] LFSR_SEED = 32'hACE1_2345;

    // Config word layout: {sweep_len, freq_step, freq_start}, freq_start at bit 0.
    localparam int CFG_LEN_W = 16;

    function automatic int cfg_step_lsb(input int acc_dw);
        return acc_dw;
    endfunction

    function automatic int cfg_len_lsb(input int acc_dw);
        return 2 * acc_dw;
    endfunction

endpackage

// File: rtl/dds_lfsr.sv
// 32-bit Galois LFSR used as phase dither source.
// Latency: q updates one cycle after an enabled cycle.
// No backpressure; advances only when en is high.
module dds_lfsr
    import dds_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    output logic [31:0] q
);

    logic [31:0] r_q;

    // Shift right, folding the polynomial back in when a one drops out.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_q <= LFSR_SEED;
        end else if (en) begin
            r_q <= (r_q >> 1) ^ (r_q[0] ? LFSR_POLY : 32'h0000_0000);
        end
    end

    assign q = r_q;

endmodule

// File: rtl/dds_phase_gen.sv
// Phase accumulator with constant/sweep frequency, resync and optional dither.
// Latency: en at cycle t gives tvalid/tdata at t+1.
// No backpressure on the phase output; config is always accepted outside reset.
module dds_phase_gen
    import dds_pkg::*;
#(
    parameter int ACC_DW     = 32,
    parameter int PHASE_DW   = 16,
    parameter int USE_DITHER = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [2*ACC_DW+15:0]  s_axis_cfg_tdata,
    input  logic                  s_axis_cfg_tvalid,
    output logic                  s_axis_cfg_tready,
    input  logic                  en,
    input  logic                  sync,
    output logic [PHASE_DW-1:0]   m_axis_phase_tdata,
    output logic                  m_axis_phase_tvalid,
    output logic                  sweep_done
);

    localparam int DITH_W       = ACC_DW - PHASE_DW;
    localparam int CFG_STEP_LSB = cfg_step_lsb(ACC_DW);
    localparam int CFG_LEN_LSB  = cfg_len_lsb(ACC_DW);
    localparam logic [31:0] DITH_MASK = 32'((64'd1 << DITH_W) - 64'd1);

    if (PHASE_DW < 1 || PHASE_DW > ACC_DW || DITH_W > 32) begin : g_param_chk
        $error("dds_phase_gen: need 1 <= PHASE_DW <= ACC_DW and ACC_DW-PHASE_DW <= 32");
    end

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ACC_DW-1:0]     r_acc;
    logic [ACC_DW-1:0]     r_freq;
    logic [ACC_DW-1:0]     r_step;
    logic [CFG_LEN_W-1:0]  r_cnt;
    logic [PHASE_DW-1:0]   r_tdata;
    logic                  r_tvalid;
    logic                  r_sweep_done;

    logic                  w_cfg_fire;
    logic [ACC_DW-1:0]     w_cfg_start;
    logic [ACC_DW-1:0]     w_cfg_step;
    logic [CFG_LEN_W-1:0]  w_cfg_len;
    logic                  w_sample;
    logic                  w_sweep_step;
    logic                  w_sweep_last;
    logic [ACC_DW-1:0]     w_base;
    logic [ACC_DW-1:0]     w_dither;
    logic [ACC_DW-1:0]     w_dithered;
    logic [PHASE_DW-1:0]   w_phase;

    assign s_axis_cfg_tready = !reset;
    assign w_cfg_fire  = s_axis_cfg_tvalid && s_axis_cfg_tready;
    assign w_cfg_start = s_axis_cfg_tdata[ACC_DW-1:0];
    assign w_cfg_step  = s_axis_cfg_tdata[CFG_STEP_LSB +: ACC_DW];
    assign w_cfg_len   = s_axis_cfg_tdata[CFG_LEN_LSB +: CFG_LEN_W];

    // A sample is produced on every en cycle once configured. A config landing on
    // the same cycle wins over the sweep step, so that sample uses the old freq.
    assign w_sample     = en && (r_state != IDLE);
    assign w_sweep_step = w_sample && (r_state == SWEEP) && !w_cfg_fire;
    assign w_sweep_last = w_sweep_step && (r_cnt == 16'd1);

    assign w_base     = sync ? '0 : r_acc;
    assign w_dithered = w_base + w_dither;
    // Shift rather than slice so the carry from the dither bits is visibly used.
    assign w_phase    = PHASE_DW'(w_dithered >> DITH_W);

    if (USE_DITHER != 0 && DITH_W > 0) begin : g_dither
        logic [31:0] w_lfsr_q;

        dds_lfsr u_lfsr (
            .clk   (clk),
            .reset (reset),
            .en    (en),
            .q     (w_lfsr_q)
        );

        assign w_dither = ACC_DW'(w_lfsr_q & DITH_MASK);
    end else begin : g_no_dither
        assign w_dither = '0;
    end

    // Next state: config selects SWEEP or RUN; the last sweep sample drops to RUN.
    always_comb begin
        w_state_nxt = r_state;
        if (w_cfg_fire) begin
            w_state_nxt = (w_cfg_len != '0) ? SWEEP : RUN;
        end else if (w_sweep_last) begin
            w_state_nxt = RUN;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Frequency, step and sweep counter: loaded by config, stepped while sweeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_freq <= '0;
            r_step <= '0;
            r_cnt  <= '0;
        end else if (w_cfg_fire) begin
            r_freq <= w_cfg_start;
            r_step <= w_cfg_step;
            r_cnt  <= w_cfg_len;
        end else if (w_sweep_step) begin
            r_freq <= r_freq + r_step;
            r_cnt  <= r_cnt - 16'd1;
        end
    end

    // Phase accumulator; config leaves it alone so phase stays continuous.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc <= '0;
        end else if (w_sample) begin
            r_acc <= w_base + r_freq;
        end else if (sync && (r_state != IDLE)) begin
            r_acc <= '0;
        end
    end

    // Output registers; tdata holds between samples.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tdata      <= '0;
            r_tvalid     <= 1'b0;
            r_sweep_done <= 1'b0;
        end else begin
            r_tvalid     <= w_sample;
            r_sweep_done <= w_sweep_last;
            if (w_sample) begin
                r_tdata <= w_phase;
            end
        end
    end

    assign m_axis_phase_tdata  = r_tdata;
    assign m_axis_phase_tvalid = r_tvalid;
    assign sweep_done          = r_sweep_done;

endmodule
